cam_stream_arbiter: RTL and testbench

//  Frame-synchronous 2:1 arbiter sharing the single RAW10 image pipe between camera 0 and camera 1.

---
 rtl/cam_stream_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_cam_stream_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_stream_arbiter.sv
// rtl/cam_stream_arbiter.sv - frame-synchronous 2:1 camera stream arbiter
//
// Shares one RAW pixel pipe between camera 0 and camera 1. The output source
// only changes while the owning camera is between frames, so the image pipe
// never sees a truncated frame. A switch is requested by software
// (sw_req_i/sw_sel_i) or raised automatically every frames_per_src_i frames.
//
// Ports
//   clk_i            pixel clock, all logic on the rising edge
//   reset            synchronous active-high reset
//   sw_req_i         1-cycle pulse: switch to source sw_sel_i
//   sw_sel_i         requested source, sampled with sw_req_i
//   auto_en_i        alternate sources every frames_per_src_i frames
//   frames_per_src_i frames per source in auto mode (0 behaves as 1)
//   cam0_*/cam1_*    frame valid, line valid and pixel of each camera
//   fv_o/lv_o/data_o forwarded stream, 1-cycle latency, data_o=0 when lv_o=0
//   active_src_o     source currently owning the output
//   busy_o           waiting for a source or a switch is pending
//   switch_done_o    1-cycle pulse when a source has been acquired
//   err_o            sticky: acquisition wait timed out

module cam_stream_arbiter #(
  parameter int DW          = 10,
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic          clk_i,
  input  logic          reset,
  input  logic          sw_req_i,
  input  logic          sw_sel_i,
  input  logic          auto_en_i,
  input  logic [7:0]    frames_per_src_i,
  input  logic          cam0_fv_i,
  input  logic          cam0_lv_i,
  input  logic [DW-1:0] cam0_data_i,
  input  logic          cam1_fv_i,
  input  logic          cam1_lv_i,
  input  logic [DW-1:0] cam1_data_i,
  output logic          fv_o,
  output logic          lv_o,
  output logic [DW-1:0] data_o,
  output logic          active_src_o,
  output logic          busy_o,
  output logic          switch_done_o,
  output logic          err_o
);

  localparam int              WCW       = $clog2(TIMEOUT_CYC);
  localparam logic [WCW-1:0]  WAIT_LAST = WCW'(TIMEOUT_CYC - 1);

  typedef enum logic {
    S_WAIT   = 1'b0,
    S_STREAM = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic            sel_q, sel_d;
  logic            target_q, target_d;
  logic            pending_q, pending_d;
  logic [7:0]      frame_cnt_q, frame_cnt_d;
  logic [WCW-1:0]  wait_cnt_q, wait_cnt_d;
  logic            fv_prev_q, fv_prev_d;
  logic            err_q, err_d;
  logic            fv_o_q, fv_o_d;
  logic            lv_o_q, lv_o_d;
  logic [DW-1:0]   data_o_q, data_o_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  // Selected-source view of the camera inputs.
  logic            cur_fv;
  logic            cur_lv;
  logic [DW-1:0]   cur_data;
  // In S_WAIT a request issued this cycle already decides which camera we
  // wait on, so an immediately idle camera is acquired without extra delay.
  logic            eff_target;
  logic            tgt_fv;
  logic [7:0]      fps_m1;
  logic            fv_fall;
  logic            auto_hit;
  logic            fwd_lv;

  always_comb begin
    cur_fv     = sel_q ? cam1_fv_i   : cam0_fv_i;
    cur_lv     = sel_q ? cam1_lv_i   : cam0_lv_i;
    cur_data   = sel_q ? cam1_data_i : cam0_data_i;
    eff_target = sw_req_i ? sw_sel_i : target_q;
    tgt_fv     = eff_target ? cam1_fv_i : cam0_fv_i;
    fps_m1     = (frames_per_src_i == 8'd0) ? 8'd0 : frames_per_src_i - 8'd1;
    fv_fall    = fv_prev_q & ~cur_fv;
    // >= rather than == so that lowering frames_per_src_i mid-run still
    // expires on the next frame instead of after a counter wrap.
    auto_hit   = auto_en_i & fv_fall & (frame_cnt_q >= fps_m1);
    fwd_lv     = cur_fv & cur_lv;
  end

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    target_d    = target_q;
    pending_d   = pending_q;
    frame_cnt_d = frame_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    fv_prev_d   = fv_prev_q;
    err_d       = err_q;
    fv_o_d      = 1'b0;
    lv_o_d      = 1'b0;
    data_o_d    = '0;
    done_d      = 1'b0;

    if (sw_req_i) begin
      err_d = 1'b0;
    end

    case (state_q)
      S_WAIT: begin
        target_d = eff_target;
        if (sw_req_i) begin
          wait_cnt_d = '0;
        end
        if (!tgt_fv) begin
          // Target is between frames: take it now; the first rising fv seen
          // from here on starts a complete frame.
          state_d     = S_STREAM;
          sel_d       = eff_target;
          frame_cnt_d = 8'd0;
          pending_d   = 1'b0;
          fv_prev_d   = 1'b0;
          wait_cnt_d  = '0;
          done_d      = 1'b1;
        end else if (!sw_req_i) begin
          if (wait_cnt_q == WAIT_LAST) begin
            err_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + WCW'(1);
          end
        end
      end

      S_STREAM: begin
        fv_o_d    = cur_fv;
        lv_o_d    = fwd_lv;
        data_o_d  = fwd_lv ? cur_data : '0;
        fv_prev_d = cur_fv;

        if (fv_fall) begin
          frame_cnt_d = (frame_cnt_q >= fps_m1) ? 8'd0 : frame_cnt_q + 8'd1;
        end

        // A software request in the same cycle as an auto expiry wins,
        // including a request that merely cancels.
        if (sw_req_i) begin
          if (sw_sel_i != sel_q) begin
            pending_d = 1'b1;
            target_d  = sw_sel_i;
          end else begin
            pending_d = 1'b0;
          end
        end else if (auto_hit) begin
          pending_d = 1'b1;
          target_d  = ~sel_q;
        end

        // Leave only while the current source is outside a frame; this cycle
        // is still forwarded (fv low), so nothing of the frame is lost.
        if (pending_d && !cur_fv) begin
          state_d     = S_WAIT;
          pending_d   = 1'b0;
          frame_cnt_d = 8'd0;
          wait_cnt_d  = '0;
        end
      end

      default: begin
        state_d = S_WAIT;
      end
    endcase

    busy_d = (state_d == S_WAIT) | pending_d;
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_q     <= S_WAIT;
      sel_q       <= 1'b0;
      target_q    <= 1'b0;
      pending_q   <= 1'b0;
      frame_cnt_q <= 8'd0;
      wait_cnt_q  <= '0;
      fv_prev_q   <= 1'b0;
      err_q       <= 1'b0;
      fv_o_q      <= 1'b0;
      lv_o_q      <= 1'b0;
      data_o_q    <= '0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      target_q    <= target_d;
      pending_q   <= pending_d;
      frame_cnt_q <= frame_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      fv_prev_q   <= fv_prev_d;
      err_q       <= err_d;
      fv_o_q      <= fv_o_d;
      lv_o_q      <= lv_o_d;
      data_o_q    <= data_o_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign fv_o          = fv_o_q;
  assign lv_o          = lv_o_q;
  assign data_o        = data_o_q;
  assign active_src_o  = sel_q;
  assign busy_o        = busy_q;
  assign switch_done_o = done_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_cam_stream_arbiter.sv
// tb/tb_cam_stream_arbiter.sv - self-checking bench for cam_stream_arbiter

module tb_cam_stream_arbiter;

  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          reset;
  logic          sw_req, sw_sel, auto_en;
  logic [7:0]    fps;
  logic          c0_fv, c0_lv, c1_fv, c1_lv;
  logic [DW-1:0] c0_data, c1_data;
  logic          fv_o, lv_o, active_src_o, busy_o, switch_done_o, err_o;
  logic [DW-1:0] data_o;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] pix_q[$];
  logic          frm_q[$];
  logic [3:0]    frame_id = 4'd0;
  logic          mon_en = 1'b0;
  logic          fv_o_prev = 1'b0;

  typedef struct {
    logic sel;
    int   exp_done;
    logic exp_src;
  } sw_vec_t;

  typedef struct {
    logic [7:0] fps;
    int         nfrm;
    logic [7:0] order;
  } auto_vec_t;

  sw_vec_t   sw_tab[6];
  auto_vec_t auto_tab[4];

  cam_stream_arbiter #(.DW(DW), .TIMEOUT_CYC(16)) dut (
    .clk_i(clk), .reset(reset),
    .sw_req_i(sw_req), .sw_sel_i(sw_sel),
    .auto_en_i(auto_en), .frames_per_src_i(fps),
    .cam0_fv_i(c0_fv), .cam0_lv_i(c0_lv), .cam0_data_i(c0_data),
    .cam1_fv_i(c1_fv), .cam1_lv_i(c1_lv), .cam1_data_i(c1_data),
    .fv_o(fv_o), .lv_o(lv_o), .data_o(data_o),
    .active_src_o(active_src_o), .busy_o(busy_o),
    .switch_done_o(switch_done_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Output scoreboard: every forwarded pixel and every frame start is popped
  // against what the stimulus side queued.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("lv_implies_fv", {31'd0, lv_o & ~fv_o}, 32'd0);
      if (lv_o) begin
        if (pix_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pixel_unexpected actual=%0h required=none", data_o);
        end else begin
          chk("pixel", {22'd0, data_o}, {22'd0, pix_q.pop_front()});
        end
      end else begin
        chk("data_zero_idle", {22'd0, data_o}, 32'd0);
      end
      if (fv_o && !fv_o_prev) begin
        if (frm_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_unexpected actual=%0d required=none", active_src_o);
        end else begin
          chk("frame_src", {31'd0, active_src_o}, {31'd0, frm_q.pop_front()});
        end
      end
      fv_o_prev = fv_o;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cams_idle();
    c0_fv = 1'b0; c0_lv = 1'b0; c0_data = DW'($urandom);
    c1_fv = 1'b0; c1_lv = 1'b0; c1_data = DW'($urandom);
  endtask

  task automatic do_reset(input logic chk_vals);
    reset = 1'b1;
    sw_req = 1'b0;
    cams_idle();
    step();
    step();
    mon_en = 1'b1;
    if (chk_vals) begin
      chk("rst_fv", {31'd0, fv_o}, 32'd0);
      chk("rst_lv", {31'd0, lv_o}, 32'd0);
      chk("rst_data", {22'd0, data_o}, 32'd0);
      chk("rst_src", {31'd0, active_src_o}, 32'd0);
      chk("rst_busy", {31'd0, busy_o}, 32'd1);
      chk("rst_done", {31'd0, switch_done_o}, 32'd0);
      chk("rst_err", {31'd0, err_o}, 32'd0);
    end
    reset = 1'b0;
    step();
    chk("acq_done", {31'd0, switch_done_o}, 32'd1);
    chk("acq_busy", {31'd0, busy_o}, 32'd0);
    chk("acq_src", {31'd0, active_src_o}, 32'd0);
  endtask

  // One frame of 4 lines x 8 px on camera cam: fv high 41 cycles, 3 blank.
  task automatic run_frame(input logic cam, input logic fwd, input logic other_fv,
                           input int r1, input logic r1_sel,
                           input int r2, input logic r2_sel,
                           output logic busy1, output logic busy2, output logic done_seen);
    logic          fv, lv;
    logic [DW-1:0] d;
    int            ln, px;
    busy1 = 1'b0;
    busy2 = 1'b0;
    done_seen = 1'b0;
    frame_id++;
    if (fwd) frm_q.push_back(cam);
    for (int s = 0; s < 44; s++) begin
      fv = (s < 41);
      ln = (s - 1) / 10;
      px = (s - 1) % 10;
      lv = fv && (s >= 1) && (px < 8);
      d  = lv ? {cam, frame_id, ln[1:0], px[2:0]} : DW'($urandom);
      if (cam) begin
        c1_fv = fv; c1_lv = lv; c1_data = d;
        c0_fv = other_fv; c0_lv = 1'b0; c0_data = DW'($urandom);
      end else begin
        c0_fv = fv; c0_lv = lv; c0_data = d;
        c1_fv = other_fv; c1_lv = 1'b0; c1_data = DW'($urandom);
      end
      sw_req = (s == r1) || (s == r2);
      sw_sel = (s == r2) ? r2_sel : r1_sel;
      if (fwd && lv) pix_q.push_back(d);
      if (s == 0 && fwd) chk("fv_before_frame", {31'd0, fv_o}, 32'd0);
      step();
      sw_req = 1'b0;
      if (s == r1) busy1 = busy_o;
      if (s == r2) busy2 = busy_o;
      if (switch_done_o) done_seen = 1'b1;
      if (s == 0 && fwd) begin
        chk("fv_latency", {31'd0, fv_o}, 32'd1);
        chk("frame_owner", {31'd0, active_src_o}, {31'd0, cam});
      end
    end
  endtask

  initial begin
    logic b1, b2, ds;
    int   dcnt;
    logic [DW-1:0] d;

    sw_tab[0] = '{1'b1, 1, 1'b1};
    sw_tab[1] = '{1'b1, 0, 1'b1};
    sw_tab[2] = '{1'b0, 1, 1'b0};
    sw_tab[3] = '{1'b0, 0, 1'b0};
    sw_tab[4] = '{1'b1, 1, 1'b1};
    sw_tab[5] = '{1'b0, 1, 1'b0};

    auto_tab[0] = '{8'd2, 6, 8'b0000_1100};
    auto_tab[1] = '{8'd0, 4, 8'b0000_1010};
    auto_tab[2] = '{8'd3, 6, 8'b0011_1000};
    auto_tab[3] = '{8'd1, 4, 8'b0000_1010};

    reset = 1'b1; sw_req = 1'b0; sw_sel = 1'b0; auto_en = 1'b0; fps = 8'd1;
    cams_idle();

    // Reset values, acquisition of camera 0, forwarding.
    do_reset(1'b1);
    step();
    chk("done_one_cycle", {31'd0, switch_done_o}, 32'd0);
    run_frame(1'b0, 1'b1, 1'b0, -1, 1'b0, -1, 1'b0, b1, b2, ds);
    run_frame(1'b0, 1'b1, 1'b0, -1, 1'b0, -1, 1'b0, b1, b2, ds);

    // Switch requests while both cameras are idle.
    for (int i = 0; i < 6; i++) begin
      cams_idle();
      sw_req = 1'b1;
      sw_sel = sw_tab[i].sel;
      step();
      sw_req = 1'b0;
      dcnt = 0;
      for (int k = 0; k < 3; k++) begin
        step();
        if (switch_done_o) dcnt++;
      end
      chk("tab_done", dcnt, sw_tab[i].exp_done);
      chk("tab_src", {31'd0, active_src_o}, {31'd0, sw_tab[i].exp_src});
      chk("tab_busy", {31'd0, busy_o}, 32'd0);
    end

    // Mid-frame request to cam1 while cam1 is inside a frame.
    run_frame(1'b0, 1'b1, 1'b1, 15, 1'b1, -1, 1'b0, b1, b2, ds);
    chk("t2_busy_pending", {31'd0, b1}, 32'd1);
    chk("t2_no_done_yet", {31'd0, ds}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      c0_fv = 1'b0; c0_lv = 1'b0;
      c1_fv = 1'b1; c1_lv = 1'b0;
      step();
    end
    chk("t2_wait_fv", {31'd0, fv_o}, 32'd0);
    chk("t2_wait_busy", {31'd0, busy_o}, 32'd1);
    c1_fv = 1'b0;
    step();
    chk("t2_done", {31'd0, switch_done_o}, 32'd1);
    chk("t2_src", {31'd0, active_src_o}, 32'd1);
    run_frame(1'b1, 1'b1, 1'b0, -1, 1'b0, -1, 1'b0, b1, b2, ds);

    // Auto alternation, frame order taken from the table.
    for (int i = 0; i < 4; i++) begin
      auto_en = 1'b1;
      fps = auto_tab[i].fps;
      do_reset(1'b0);
      for (int f = 0; f < auto_tab[i].nfrm; f++) begin
        run_frame(auto_tab[i].order[f], 1'b1, 1'b0, -1, 1'b0, -1, 1'b0, b1, b2, ds);
      end
      chk("t3_frames_left", frm_q.size(), 0);
      frm_q.delete();
      pix_q.delete();
    end
    auto_en = 1'b0;
    fps = 8'd1;
    do_reset(1'b0);

    // Request then cancel within one frame.
    run_frame(1'b0, 1'b1, 1'b0, 10, 1'b1, 20, 1'b0, b1, b2, ds);
    chk("t4_busy_req", {31'd0, b1}, 32'd1);
    chk("t4_busy_cancel", {31'd0, b2}, 32'd0);
    chk("t4_no_done", {31'd0, ds}, 32'd0);
    chk("t4_src", {31'd0, active_src_o}, 32'd0);
    run_frame(1'b0, 1'b1, 1'b0, -1, 1'b0, -1, 1'b0, b1, b2, ds);

    // Acquisition timeout with cam1 stuck inside a frame.
    cams_idle();
    c1_fv = 1'b1;
    sw_req = 1'b1; sw_sel = 1'b1;
    step();
    sw_req = 1'b0;
    chk("t5_busy", {31'd0, busy_o}, 32'd1);
    for (int k = 1; k <= 15; k++) step();
    chk("t5_err_before", {31'd0, err_o}, 32'd0);
    step();
    chk("t5_err_at", {31'd0, err_o}, 32'd1);
    chk("t5_fv", {31'd0, fv_o}, 32'd0);
    chk("t5_lv", {31'd0, lv_o}, 32'd0);
    step();
    chk("t5_err_sticky", {31'd0, err_o}, 32'd1);
    sw_req = 1'b1; sw_sel = 1'b0;
    step();
    sw_req = 1'b0;
    chk("t5_err_clear", {31'd0, err_o}, 32'd0);
    chk("t5_done", {31'd0, switch_done_o}, 32'd1);
    chk("t5_src", {31'd0, active_src_o}, 32'd0);
    c1_fv = 1'b0;
    run_frame(1'b0, 1'b1, 1'b0, -1, 1'b0, -1, 1'b0, b1, b2, ds);

    // Reset in the middle of a line.
    frame_id++;
    frm_q.push_back(1'b0);
    for (int s = 0; s < 5; s++) begin
      c0_fv = 1'b1;
      c0_lv = (s >= 1);
      d = {1'b0, frame_id, 5'(s)};
      c0_data = d;
      if (s >= 1) pix_q.push_back(d);
      step();
    end
    c0_lv = 1'b1;
    c0_data = DW'($urandom);
    reset = 1'b1;
    step();
    chk("t6_fv", {31'd0, fv_o}, 32'd0);
    chk("t6_lv", {31'd0, lv_o}, 32'd0);
    chk("t6_data", {22'd0, data_o}, 32'd0);
    chk("t6_src", {31'd0, active_src_o}, 32'd0);
    chk("t6_busy", {31'd0, busy_o}, 32'd1);
    reset = 1'b0;
    for (int s = 0; s < 5; s++) begin
      c0_fv = 1'b1;
      c0_lv = s[0];
      c0_data = DW'($urandom);
      step();
    end
    chk("t6_wait_fv", {31'd0, fv_o}, 32'd0);
    chk("t6_wait_done", {31'd0, switch_done_o}, 32'd0);
    c0_fv = 1'b0;
    c0_lv = 1'b0;
    step();
    chk("t6_reacq_done", {31'd0, switch_done_o}, 32'd1);
    chk("t6_reacq_src", {31'd0, active_src_o}, 32'd0);
    run_frame(1'b0, 1'b1, 1'b0, -1, 1'b0, -1, 1'b0, b1, b2, ds);

    step();
    chk("pixels_left", pix_q.size(), 0);
    chk("frames_left", frm_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
